// File: rtl/inference_accuracy_monitor.sv
// Scores inference results against a queue of expected labels.
// Keeps saturating hit/total/invalid/orphan/per-class counters and sticky error flags.
module inference_accuracy_monitor #(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned LABEL_W     = 4,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LABEL_W-1:0]     label_in,
  input  logic                   label_push,
  output logic                   label_full,
  output logic                   label_empty,
  input  logic                   valid,
  input  logic [NUM_CLASSES-1:0] data_out,
  input  logic                   clear,
  input  logic [LABEL_W-1:0]     class_sel,
  output logic                   pred_valid,
  output logic [LABEL_W-1:0]     pred_class,
  output logic                   pred_hit,
  output logic [CNT_W-1:0]       total_cnt,
  output logic [CNT_W-1:0]       correct_cnt,
  output logic [CNT_W-1:0]       invalid_cnt,
  output logic [CNT_W-1:0]       orphan_cnt,
  output logic [CNT_W-1:0]       class_hit_cnt,
  output logic                   overflow,
  output logic                   drop_err
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int NumCls = int'(NUM_CLASSES);
  localparam logic [PtrW:0] DepthC = (PtrW + 1)'(FIFO_DEPTH);
  localparam logic [LABEL_W-1:0] InvalidClass = LABEL_W'(NUM_CLASSES);
  localparam logic [CNT_W-1:0] CntMax = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CntMax) ? v : v + CNT_W'(1);
  endfunction

  logic                   valid_q;
  logic [LABEL_W-1:0]     fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]          count_q, count_d;
  logic [CNT_W-1:0]       total_q, total_d;
  logic [CNT_W-1:0]       correct_q, correct_d;
  logic [CNT_W-1:0]       invalid_q, invalid_d;
  logic [CNT_W-1:0]       orphan_q, orphan_d;
  logic [CNT_W-1:0]       class_hit_q [NUM_CLASSES];
  logic [CNT_W-1:0]       class_hit_d [NUM_CLASSES];
  logic [CNT_W-1:0]       class_hit_cnt_q, class_hit_cnt_d;
  logic                   overflow_q, overflow_d;
  logic                   drop_err_q, drop_err_d;
  logic                   pred_valid_q;
  logic [LABEL_W-1:0]     pred_class_q, pred_class_d;
  logic                   pred_hit_q;

  logic                   accept, empty, full, pop, push, drop, hit, ovf_evt;
  logic                   dec_onehot;
  logic [LABEL_W-1:0]     dec_class, head;

  assign empty  = (count_q == '0);
  assign full   = (count_q == DepthC);
  assign accept = valid & ~valid_q;
  assign pop    = accept & ~empty;
  // A simultaneous pop frees a slot, so a push into a full queue still lands.
  assign push   = label_push & (~full | pop);
  assign drop   = label_push & full & ~pop;
  assign head   = fifo_q[rd_ptr_q];

  always_comb begin
    dec_onehot = (data_out != '0) && ((data_out & (data_out - NUM_CLASSES'(1))) == '0);
    dec_class  = InvalidClass;
    for (int i = 0; i < NumCls; i++) begin
      if (data_out[i]) dec_class = LABEL_W'(NumCls - 1 - i);
    end
    if (!dec_onehot) dec_class = InvalidClass;
  end

  // Labels >= NUM_CLASSES can never equal a valid decode, so they never hit.
  assign hit = pop & dec_onehot & (dec_class == head);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PtrW + 1)'(1);
      2'b01:   count_d = count_q - (PtrW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    total_d     = total_q;
    correct_d   = correct_q;
    invalid_d   = invalid_q;
    orphan_d    = orphan_q;
    class_hit_d = class_hit_q;
    ovf_evt     = 1'b0;
    if (pop) begin
      total_d = sat_inc(total_q);
      ovf_evt |= (total_q == CntMax);
    end
    if (hit) begin
      correct_d = sat_inc(correct_q);
      ovf_evt |= (correct_q == CntMax);
    end
    if (pop && !dec_onehot) begin
      invalid_d = sat_inc(invalid_q);
      ovf_evt |= (invalid_q == CntMax);
    end
    if (accept && empty) begin
      orphan_d = sat_inc(orphan_q);
      ovf_evt |= (orphan_q == CntMax);
    end
    for (int c = 0; c < NumCls; c++) begin
      if (hit && head == LABEL_W'(c)) begin
        class_hit_d[c] = sat_inc(class_hit_q[c]);
        ovf_evt |= (class_hit_q[c] == CntMax);
      end
    end
    overflow_d = overflow_q | ovf_evt;
    drop_err_d = drop_err_q | drop;
    if (clear) begin
      total_d     = '0;
      correct_d   = '0;
      invalid_d   = '0;
      orphan_d    = '0;
      class_hit_d = '{default: '0};
      overflow_d  = 1'b0;
      drop_err_d  = 1'b0;
    end
  end

  always_comb begin
    class_hit_cnt_d = '0;
    for (int c = 0; c < NumCls; c++) begin
      if (class_sel == LABEL_W'(c)) class_hit_cnt_d = class_hit_q[c];
    end
  end

  assign pred_class_d = accept ? dec_class : pred_class_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q         <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      total_q         <= '0;
      correct_q       <= '0;
      invalid_q       <= '0;
      orphan_q        <= '0;
      class_hit_q     <= '{default: '0};
      class_hit_cnt_q <= '0;
      overflow_q      <= 1'b0;
      drop_err_q      <= 1'b0;
      pred_valid_q    <= 1'b0;
      pred_class_q    <= '0;
      pred_hit_q      <= 1'b0;
    end else begin
      valid_q         <= valid;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q         <= count_d;
      total_q         <= total_d;
      correct_q       <= correct_d;
      invalid_q       <= invalid_d;
      orphan_q        <= orphan_d;
      class_hit_q     <= class_hit_d;
      class_hit_cnt_q <= class_hit_cnt_d;
      overflow_q      <= overflow_d;
      drop_err_q      <= drop_err_d;
      pred_valid_q    <= accept;
      pred_class_q    <= pred_class_d;
      pred_hit_q      <= hit;
    end
  end

  // Storage needs no reset; occupancy alone decides what is readable.
  always_ff @(posedge clk) begin
    if (rst && push) fifo_q[wr_ptr_q] <= label_in;
  end

  assign label_full    = full;
  assign label_empty   = empty;
  assign pred_valid    = pred_valid_q;
  assign pred_class    = pred_class_q;
  assign pred_hit      = pred_hit_q;
  assign total_cnt     = total_q;
  assign correct_cnt   = correct_q;
  assign invalid_cnt   = invalid_q;
  assign orphan_cnt    = orphan_q;
  assign class_hit_cnt = class_hit_cnt_q;
  assign overflow      = overflow_q;
  assign drop_err      = drop_err_q;

endmodule

// File: tb/tb_inference_accuracy_monitor.sv
// Directed bench for inference_accuracy_monitor: a vector table plus hand sequences
// for full queue, clear, reset and counter saturation (second instance, CNT_W=3).
module tb_inference_accuracy_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] label_in;
  logic       label_push;
  logic       valid;
  logic [9:0] data_out;
  logic       clear;
  logic [3:0] class_sel;

  logic        label_full, label_empty, pred_valid, pred_hit, overflow, drop_err;
  logic [3:0]  pred_class;
  logic [15:0] total_cnt, correct_cnt, invalid_cnt, orphan_cnt, class_hit_cnt;

  logic       s_full, s_empty, s_pv, s_ph, s_ovf, s_drop;
  logic [3:0] s_pc;
  logic [2:0] s_tot, s_cor, s_inv, s_orp, s_chc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inference_accuracy_monitor dut (
    .clk(clk), .rst(rst), .label_in(label_in), .label_push(label_push),
    .label_full(label_full), .label_empty(label_empty), .valid(valid),
    .data_out(data_out), .clear(clear), .class_sel(class_sel),
    .pred_valid(pred_valid), .pred_class(pred_class), .pred_hit(pred_hit),
    .total_cnt(total_cnt), .correct_cnt(correct_cnt), .invalid_cnt(invalid_cnt),
    .orphan_cnt(orphan_cnt), .class_hit_cnt(class_hit_cnt), .overflow(overflow),
    .drop_err(drop_err)
  );

  inference_accuracy_monitor #(.CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .label_in(label_in), .label_push(label_push),
    .label_full(s_full), .label_empty(s_empty), .valid(valid),
    .data_out(data_out), .clear(clear), .class_sel(class_sel),
    .pred_valid(s_pv), .pred_class(s_pc), .pred_hit(s_ph),
    .total_cnt(s_tot), .correct_cnt(s_cor), .invalid_cnt(s_inv),
    .orphan_cnt(s_orp), .class_hit_cnt(s_chc), .overflow(s_ovf),
    .drop_err(s_drop)
  );

  typedef struct {
    int push, label, vld, data, sel;
    int pv, pc, ph, tot, cor, inv, orp, chc, full, empty;
  } vec_t;

  vec_t tbl [27];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int push, input int label, input int vld, input int data);
    label_push = push[0];
    label_in   = label[3:0];
    valid      = vld[0];
    data_out   = data[9:0];
  endtask

  initial begin
    //            push lbl v data sel  pv pc ph tot cor inv orp chc full empty
    tbl[0]  = '{1, 3, 0, 0,   3,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 1, 64,  3,   1, 3, 1, 1, 1, 0, 0, 0, 0, 1};
    tbl[2]  = '{0, 0, 0, 0,   3,   0, 3, 0, 1, 1, 0, 0, 1, 0, 1};
    tbl[3]  = '{1, 0, 0, 0,   3,   0, 3, 0, 1, 1, 0, 0, 1, 0, 0};
    tbl[4]  = '{1, 7, 0, 0,   3,   0, 3, 0, 1, 1, 0, 0, 1, 0, 0};
    tbl[5]  = '{1, 9, 1, 512, 3,   1, 0, 1, 2, 2, 0, 0, 1, 0, 0};
    tbl[6]  = '{0, 0, 0, 0,   3,   0, 0, 0, 2, 2, 0, 0, 1, 0, 0};
    tbl[7]  = '{0, 0, 1, 2,   3,   1, 8, 0, 3, 2, 0, 0, 1, 0, 0};
    tbl[8]  = '{0, 0, 0, 0,   3,   0, 8, 0, 3, 2, 0, 0, 1, 0, 0};
    tbl[9]  = '{0, 0, 1, 1,   3,   1, 9, 1, 4, 3, 0, 0, 1, 0, 1};
    tbl[10] = '{0, 0, 0, 0,   9,   0, 9, 0, 4, 3, 0, 0, 1, 0, 1};
    tbl[11] = '{1, 5, 0, 0,   0,   0, 9, 0, 4, 3, 0, 0, 1, 0, 0};
    tbl[12] = '{0, 0, 1, 0,   0,   1, 10, 0, 5, 3, 1, 0, 1, 0, 1};
    tbl[13] = '{0, 0, 0, 0,   0,   0, 10, 0, 5, 3, 1, 0, 1, 0, 1};
    tbl[14] = '{0, 0, 1, 16,  0,   1, 5, 0, 5, 3, 1, 1, 1, 0, 1};
    tbl[15] = '{0, 0, 0, 0,   12,  0, 5, 0, 5, 3, 1, 1, 0, 0, 1};
    tbl[16] = '{1, 3, 0, 0,   3,   0, 5, 0, 5, 3, 1, 1, 1, 0, 0};
    tbl[17] = '{0, 0, 1, 64,  3,   1, 3, 1, 6, 4, 1, 1, 1, 0, 1};
    tbl[18] = '{0, 0, 1, 64,  3,   0, 3, 0, 6, 4, 1, 1, 2, 0, 1};
    tbl[19] = '{0, 0, 1, 64,  3,   0, 3, 0, 6, 4, 1, 1, 2, 0, 1};
    tbl[20] = '{0, 0, 1, 64,  3,   0, 3, 0, 6, 4, 1, 1, 2, 0, 1};
    tbl[21] = '{0, 0, 1, 64,  3,   0, 3, 0, 6, 4, 1, 1, 2, 0, 1};
    tbl[22] = '{0, 0, 0, 0,   2,   0, 3, 0, 6, 4, 1, 1, 0, 0, 1};
    tbl[23] = '{1, 2, 1, 128, 2,   1, 2, 0, 6, 4, 1, 2, 0, 0, 0};
    tbl[24] = '{0, 0, 0, 0,   2,   0, 2, 0, 6, 4, 1, 2, 0, 0, 0};
    tbl[25] = '{0, 0, 1, 128, 2,   1, 2, 1, 7, 5, 1, 2, 0, 0, 1};
    tbl[26] = '{0, 0, 0, 0,   2,   0, 2, 0, 7, 5, 1, 2, 1, 0, 1};

    rst = 1'b0;
    clear = 1'b0;
    class_sel = 4'd0;
    drive(0, 0, 0, 0);
    tick();
    chk("reset empty", int'(label_empty), 1);
    chk("reset full", int'(label_full), 0);
    chk("reset total", int'(total_cnt), 0);
    chk("reset pred_valid", int'(pred_valid), 0);
    chk("reset overflow", int'(overflow), 0);
    tick();
    rst = 1'b1;

    for (int i = 0; i < 27; i++) begin
      drive(tbl[i].push, tbl[i].label, tbl[i].vld, tbl[i].data);
      class_sel = tbl[i].sel[3:0];
      tick();
      chk($sformatf("v%0d pred_valid", i), int'(pred_valid), tbl[i].pv);
      chk($sformatf("v%0d pred_class", i), int'(pred_class), tbl[i].pc);
      chk($sformatf("v%0d pred_hit", i), int'(pred_hit), tbl[i].ph);
      chk($sformatf("v%0d total", i), int'(total_cnt), tbl[i].tot);
      chk($sformatf("v%0d correct", i), int'(correct_cnt), tbl[i].cor);
      chk($sformatf("v%0d invalid", i), int'(invalid_cnt), tbl[i].inv);
      chk($sformatf("v%0d orphan", i), int'(orphan_cnt), tbl[i].orp);
      chk($sformatf("v%0d class_hit", i), int'(class_hit_cnt), tbl[i].chc);
      chk($sformatf("v%0d full", i), int'(label_full), tbl[i].full);
      chk($sformatf("v%0d empty", i), int'(label_empty), tbl[i].empty);
    end
    drive(0, 0, 0, 0);

    // Full queue, drop, then push+pop while full keeps the pushed label.
    for (int l = 1; l <= 4; l++) begin
      drive(1, l, 0, 0);
      tick();
    end
    chk("fill full", int'(label_full), 1);
    chk("fill drop_err", int'(drop_err), 0);
    drive(1, 6, 0, 0);
    tick();
    chk("drop drop_err", int'(drop_err), 1);
    chk("drop full", int'(label_full), 1);
    drive(0, 0, 0, 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear drop_err", int'(drop_err), 0);
    chk("clear total", int'(total_cnt), 0);
    chk("clear keeps queue", int'(label_full), 1);
    drive(1, 8, 1, 256);
    tick();
    chk("pushpop hit", int'(pred_hit), 1);
    chk("pushpop class", int'(pred_class), 1);
    chk("pushpop full", int'(label_full), 1);
    chk("pushpop drop_err", int'(drop_err), 0);
    drive(0, 0, 0, 0);
    tick();
    begin
      int exp_cls [4] = '{2, 3, 4, 8};
      int dat [4] = '{128, 64, 32, 2};
      for (int k = 0; k < 4; k++) begin
        drive(0, 0, 1, dat[k]);
        tick();
        chk($sformatf("drain%0d hit", k), int'(pred_hit), 1);
        chk($sformatf("drain%0d class", k), int'(pred_class), exp_cls[k]);
        drive(0, 0, 0, 0);
        tick();
      end
    end
    chk("drain empty", int'(label_empty), 1);
    chk("drain correct", int'(correct_cnt), 5);
    chk("drain total", int'(total_cnt), 5);

    // Clear coinciding with an acceptance.
    drive(1, 7, 0, 0);
    tick();
    drive(0, 0, 1, 4);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clracc pred_valid", int'(pred_valid), 1);
    chk("clracc pred_hit", int'(pred_hit), 1);
    chk("clracc pred_class", int'(pred_class), 7);
    chk("clracc total", int'(total_cnt), 0);
    chk("clracc correct", int'(correct_cnt), 0);
    chk("clracc popped", int'(label_empty), 1);
    drive(0, 0, 0, 0);
    tick();

    // Reset mid-operation with valid held through release.
    drive(1, 1, 0, 0);
    tick();
    drive(1, 2, 0, 0);
    tick();
    chk("prerst empty", int'(label_empty), 0);
    rst = 1'b0;
    drive(0, 0, 1, 0);
    tick();
    chk("rst empty", int'(label_empty), 1);
    chk("rst full", int'(label_full), 0);
    chk("rst correct", int'(correct_cnt), 0);
    chk("rst invalid", int'(invalid_cnt), 0);
    chk("rst pred_class", int'(pred_class), 0);
    chk("rst pred_hit", int'(pred_hit), 0);
    chk("rst class_hit", int'(class_hit_cnt), 0);
    tick();
    rst = 1'b1;
    tick();
    chk("release accept", int'(pred_valid), 1);
    chk("release orphan", int'(orphan_cnt), 1);
    chk("release class", int'(pred_class), 10);
    chk("release total", int'(total_cnt), 0);
    drive(0, 0, 0, 0);
    tick();

    // Saturation on the 3-bit instance.
    class_sel = 4'd2;
    for (int n = 1; n <= 8; n++) begin
      drive(1, 2, 0, 0);
      tick();
      drive(0, 0, 1, 128);
      tick();
      if (n == 7) begin
        chk("sat7 correct", int'(s_cor), 7);
        chk("sat7 overflow", int'(s_ovf), 0);
      end
      drive(0, 0, 0, 0);
      tick();
    end
    chk("sat8 correct", int'(s_cor), 7);
    chk("sat8 total", int'(s_tot), 7);
    chk("sat8 overflow", int'(s_ovf), 1);
    chk("sat8 class_hit", int'(s_chc), 7);
    chk("wide correct", int'(correct_cnt), 8);
    chk("wide overflow", int'(overflow), 0);
    drive(1, 2, 0, 0);
    tick();
    drive(0, 0, 1, 128);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("satclr pred_valid", int'(s_pv), 1);
    chk("satclr correct", int'(s_cor), 0);
    chk("satclr total", int'(s_tot), 0);
    chk("satclr overflow", int'(s_ovf), 0);
    drive(0, 0, 0, 0);
    tick();
    chk("satclr pulse", int'(s_pv), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
